// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer slice: FSM encoding and default word width.
package serial_pkg;

    localparam int SERIAL_WORD_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serial_state_t;

endpackage

// File: rtl/serial_byte_deserializer_if.sv
// Serial bit stream in, word valid/ready handshake out.
interface serial_byte_deserializer_if
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_WORD_WIDTH
);

    logic                  Serial_Data_In;
    logic                  Serial_Valid_In;
    logic                  Frame_Start_In;
    logic                  Byte_Ready_In;
    logic [DATA_WIDTH-1:0] Byte_Data_Out;
    logic                  Byte_Valid_Out;

    modport master (
        output Serial_Data_In,
        output Serial_Valid_In,
        output Frame_Start_In,
        output Byte_Ready_In,
        input  Byte_Data_Out,
        input  Byte_Valid_Out
    );

    modport slave (
        input  Serial_Data_In,
        input  Serial_Valid_In,
        input  Frame_Start_In,
        input  Byte_Ready_In,
        output Byte_Data_Out,
        output Byte_Valid_Out
    );

endinterface

// File: rtl/serial_bit_collector.sv
// Shift register and bit counter; word/word_done present the completed word combinationally
// so the parent can register it on the same edge that samples the final bit.
module serial_bit_collector
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_WORD_WIDTH,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          capture,
    input  logic                          restart,
    input  logic                          bit_in,
    output logic [DATA_WIDTH-1:0]         word,
    output logic [$clog2(DATA_WIDTH)-1:0] count,
    output logic                          word_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sreg;
    logic [DATA_WIDTH-1:0] sreg_next;

    always_comb begin
        sreg_next = sreg;
        if (LSB_FIRST) begin
            sreg_next = {bit_in, sreg[DATA_WIDTH-1:1]};
        end else begin
            sreg_next = {sreg[DATA_WIDTH-2:0], bit_in};
        end
    end

    // A restart bit is always bit 0, so it can never complete a word (DATA_WIDTH >= 2).
    assign word_done = capture & ~restart & (count == LAST);
    assign word      = sreg_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (capture) begin
            sreg <= sreg_next;
            if (restart) begin
                count <= CW'(1);
            end else if (word_done) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_byte_deserializer.sv
// Collects serial bits into words and offers them on a one-entry valid/ready register with sticky overrun.
module serial_byte_deserializer
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = SERIAL_WORD_WIDTH,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic                          Enable_In,
    input  logic                          Clear_Overrun_In,
    serial_byte_deserializer_if.slave     bus,
    output logic                          Overrun_Out,
    output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out
);

    serial_state_t         state;
    logic                  capture;
    logic                  word_done;
    logic                  accept;
    logic [DATA_WIDTH-1:0] word;

    // In IDLE only a framed bit is taken; in SHIFT every strobed bit is.
    assign capture = Enable_In & bus.Serial_Valid_In & ((state == ST_SHIFT) | bus.Frame_Start_In);
    assign accept  = bus.Byte_Valid_Out & bus.Byte_Ready_In;

    serial_bit_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_collector (
        .clk       (Clk_In),
        .rst       (Reset_In),
        .clear     (~Enable_In),
        .capture   (capture),
        .restart   (bus.Frame_Start_In),
        .bit_in    (bus.Serial_Data_In),
        .word      (word),
        .count     (Bit_Count_Out),
        .word_done (word_done)
    );

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state <= ST_IDLE;
        end else if (!Enable_In) begin
            state <= ST_IDLE;
        end else if (state == ST_IDLE && bus.Serial_Valid_In && bus.Frame_Start_In) begin
            state <= ST_SHIFT;
        end
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            bus.Byte_Data_Out  <= '0;
            bus.Byte_Valid_Out <= 1'b0;
        end else if (word_done && (!bus.Byte_Valid_Out || accept)) begin
            bus.Byte_Data_Out  <= word;
            bus.Byte_Valid_Out <= 1'b1;
        end else if (accept) begin
            bus.Byte_Valid_Out <= 1'b0;
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            Overrun_Out <= 1'b0;
        end else if (word_done && bus.Byte_Valid_Out && !accept) begin
            Overrun_Out <= 1'b1;
        end else if (Clear_Overrun_In) begin
            Overrun_Out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Directed bench for serial_byte_deserializer (8-bit, LSB first).
module tb_serial_byte_deserializer;

    logic       Clk_In = 1'b0;
    logic       Reset_In;
    logic       Enable_In;
    logic       Clear_Overrun_In;
    logic       Overrun_Out;
    logic [2:0] Bit_Count_Out;

    int checks   = 0;
    int failures = 0;

    serial_byte_deserializer_if #(.DATA_WIDTH(8)) bus ();

    serial_byte_deserializer #(
        .DATA_WIDTH (8),
        .LSB_FIRST  (1'b1)
    ) dut (
        .Clk_In           (Clk_In),
        .Reset_In         (Reset_In),
        .Enable_In        (Enable_In),
        .Clear_Overrun_In (Clear_Overrun_In),
        .bus              (bus.slave),
        .Overrun_Out      (Overrun_Out),
        .Bit_Count_Out    (Bit_Count_Out)
    );

    always #5 Clk_In = ~Clk_In;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge Clk_In);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs, input int gap);
        repeat (gap) tick();
        bus.Serial_Data_In  = b;
        bus.Frame_Start_In  = fs;
        bus.Serial_Valid_In = 1'b1;
        tick();
        bus.Serial_Valid_In = 1'b0;
        bus.Frame_Start_In  = 1'b0;
        bus.Serial_Data_In  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs, input logic gaps);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], fs && (i == 0), gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    initial begin
        Reset_In             = 1'b1;
        Enable_In            = 1'b1;
        Clear_Overrun_In     = 1'b0;
        bus.Serial_Data_In   = 1'b0;
        bus.Serial_Valid_In  = 1'b0;
        bus.Frame_Start_In   = 1'b0;
        bus.Byte_Ready_In    = 1'b0;
        repeat (2) tick();
        chk("rst_data",    32'(bus.Byte_Data_Out), 32'h0);
        chk("rst_valid",   32'(bus.Byte_Valid_Out), 32'h0);
        chk("rst_overrun", 32'(Overrun_Out), 32'h0);
        chk("rst_count",   32'(Bit_Count_Out), 32'h0);
        Reset_In = 1'b0;
        tick();

        // Reset mid-word
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        chk("mid_count3", 32'(Bit_Count_Out), 32'd3);
        Reset_In = 1'b1;
        #2;
        chk("mid_rst_count", 32'(Bit_Count_Out), 32'd0);
        chk("mid_rst_valid", 32'(bus.Byte_Valid_Out), 32'h0);
        chk("mid_rst_data",  32'(bus.Byte_Data_Out), 32'h0);
        tick();
        Reset_In = 1'b0;
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        chk("idle_no_frame_count", 32'(Bit_Count_Out), 32'd0);

        // Single word with consumer ready
        bus.Byte_Ready_In = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0);
        chk("a5_valid", 32'(bus.Byte_Valid_Out), 32'h1);
        chk("a5_data",  32'(bus.Byte_Data_Out), 32'hA5);
        chk("a5_count", 32'(Bit_Count_Out), 32'd0);
        tick();
        chk("a5_accepted", 32'(bus.Byte_Valid_Out), 32'h0);

        // Back-to-back words, consumer stalled -> overrun
        bus.Byte_Ready_In = 1'b0;
        send_word(8'h3C, 1'b1, 1'b0);
        chk("3c_valid",   32'(bus.Byte_Valid_Out), 32'h1);
        chk("3c_data",    32'(bus.Byte_Data_Out), 32'h3C);
        chk("3c_overrun", 32'(Overrun_Out), 32'h0);
        send_word(8'hC3, 1'b0, 1'b0);
        chk("c3_held_data", 32'(bus.Byte_Data_Out), 32'h3C);
        chk("c3_valid",     32'(bus.Byte_Valid_Out), 32'h1);
        chk("c3_overrun",   32'(Overrun_Out), 32'h1);
        Clear_Overrun_In = 1'b1;
        tick();
        Clear_Overrun_In = 1'b0;
        chk("ovr_cleared", 32'(Overrun_Out), 32'h0);
        chk("ovr_hold_data", 32'(bus.Byte_Data_Out), 32'h3C);
        bus.Byte_Ready_In = 1'b1;
        tick();
        bus.Byte_Ready_In = 1'b0;
        chk("3c_accepted", 32'(bus.Byte_Valid_Out), 32'h0);

        // Resync discards a partial word
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 0);
        chk("resync_count5", 32'(Bit_Count_Out), 32'd5);
        send_word(8'h81, 1'b1, 1'b0);
        chk("81_data",    32'(bus.Byte_Data_Out), 32'h81);
        chk("81_valid",   32'(bus.Byte_Valid_Out), 32'h1);
        chk("81_overrun", 32'(Overrun_Out), 32'h0);
        bus.Byte_Ready_In = 1'b1;
        tick();
        bus.Byte_Ready_In = 1'b0;
        chk("81_accepted", 32'(bus.Byte_Valid_Out), 32'h0);

        // Accept and complete in the same cycle
        send_word(8'h5A, 1'b1, 1'b0);
        chk("5a_data", 32'(bus.Byte_Data_Out), 32'h5A);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w96;
            w96 = 8'h96;
            if (i == 7) bus.Byte_Ready_In = 1'b1;
            send_bit(w96[i], 1'b0, 0);
        end
        bus.Byte_Ready_In = 1'b0;
        chk("same_cyc_valid",   32'(bus.Byte_Valid_Out), 32'h1);
        chk("same_cyc_data",    32'(bus.Byte_Data_Out), 32'h96);
        chk("same_cyc_overrun", 32'(Overrun_Out), 32'h0);
        bus.Byte_Ready_In = 1'b1;
        tick();
        chk("96_accepted", 32'(bus.Byte_Valid_Out), 32'h0);

        // Strobe gaps and enable drop
        send_word(8'hE7, 1'b1, 1'b1);
        chk("e7_valid", 32'(bus.Byte_Valid_Out), 32'h1);
        chk("e7_data",  32'(bus.Byte_Data_Out), 32'hE7);
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, int'($urandom_range(0, 3)));
        chk("dis_count4", 32'(Bit_Count_Out), 32'd4);
        Enable_In = 1'b0;
        tick();
        chk("dis_count0", 32'(Bit_Count_Out), 32'd0);
        chk("dis_valid",  32'(bus.Byte_Valid_Out), 32'h0);
        Enable_In = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0);
        chk("reen_idle_count", 32'(Bit_Count_Out), 32'd0);
        chk("reen_idle_valid", 32'(bus.Byte_Valid_Out), 32'h0);
        send_word(8'h4B, 1'b1, 1'b1);
        chk("4b_valid",   32'(bus.Byte_Valid_Out), 32'h1);
        chk("4b_data",    32'(bus.Byte_Data_Out), 32'h4B);
        chk("4b_overrun", 32'(Overrun_Out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
